// File: rtl/vram_writer.sv
// rtl/vram_writer.sv - character VRAM write side: terminal cursor, control codes, row clear.
// Optional clear-screen on form feed when VRAM_WRITER_CLS_EN is defined.
module vram_writer #(
  parameter int HTILES = 80,
  parameter int VTILES = 60,
  parameter int COL_W = 7,
  parameter int ROW_W = 6,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_data,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col,
  output logic             busy
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(HTILES - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(VTILES - 1);

  typedef enum logic [1:0] {IDLE, CLEAR_ROW, CLEAR_ALL} state_t;

  state_t           state;
  logic [COL_W-1:0] clr_col;
  logic [ROW_W-1:0] clr_row;
  logic             clr_last;

  logic             accept;
  logic             printable;
  logic             advance;
  logic             wrap;
  logic [ROW_W-1:0] bs_row;
  logic [COL_W-1:0] bs_col;

  always_comb begin
    accept    = in_valid && in_ready;
    printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
    advance   = accept && ((printable && cursor_col == COL_MAX) || in_data == 8'h0A);
    wrap      = advance && (cursor_row == ROW_MAX);
    bs_row    = cursor_row;
    bs_col    = cursor_col;
    if (cursor_col != '0) begin
      bs_col = cursor_col - 1'b1;
    end else if (cursor_row != '0) begin
      bs_row = cursor_row - 1'b1;
      bs_col = COL_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      wr_en      <= 1'b0;
      wr_row     <= '0;
      wr_col     <= '0;
      wr_data    <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      clr_row    <= '0;
      clr_col    <= '0;
      clr_last   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          if (accept) begin
            if (printable) begin
              wr_en      <= 1'b1;
              wr_row     <= cursor_row;
              wr_col     <= cursor_col;
              wr_data    <= in_data;
              cursor_col <= (cursor_col == COL_MAX) ? '0 : cursor_col + 1'b1;
            end else if (in_data == 8'h0D || in_data == 8'h0A) begin
              cursor_col <= '0;
            end else if (in_data == 8'h08) begin
              wr_en      <= 1'b1;
              wr_row     <= bs_row;
              wr_col     <= bs_col;
              wr_data    <= BLANK;
              cursor_row <= bs_row;
              cursor_col <= bs_col;
            end
`ifdef VRAM_WRITER_CLS_EN
            else if (in_data == 8'h0C) begin
              state      <= CLEAR_ALL;
              in_ready   <= 1'b0;
              busy       <= 1'b1;
              cursor_row <= '0;
              cursor_col <= '0;
              wr_en      <= 1'b1;
              wr_row     <= '0;
              wr_col     <= '0;
              wr_data    <= BLANK;
              clr_row    <= '0;
              clr_col    <= COL_W'(1);
              clr_last   <= 1'b0;
            end
`endif
            if (advance) begin
              cursor_row <= wrap ? '0 : cursor_row + 1'b1;
            end
            if (wrap) begin
              state    <= CLEAR_ROW;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              clr_row  <= '0;
              clr_col  <= '0;
              clr_last <= 1'b0;
              // A wrapping LF has no write of its own, so the clear starts right away.
              if (!printable) begin
                wr_en   <= 1'b1;
                wr_row  <= '0;
                wr_col  <= '0;
                wr_data <= BLANK;
                clr_col <= COL_W'(1);
              end
            end
          end
        end
        CLEAR_ROW: begin
          if (clr_last) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            wr_en    <= 1'b1;
            wr_row   <= '0;
            wr_col   <= clr_col;
            wr_data  <= BLANK;
            clr_col  <= (clr_col == COL_MAX) ? '0 : clr_col + 1'b1;
            clr_last <= (clr_col == COL_MAX);
          end
        end
`ifdef VRAM_WRITER_CLS_EN
        CLEAR_ALL: begin
          if (clr_last) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            wr_en    <= 1'b1;
            wr_row   <= clr_row;
            wr_col   <= clr_col;
            wr_data  <= BLANK;
            clr_last <= (clr_col == COL_MAX) && (clr_row == ROW_MAX);
            if (clr_col == COL_MAX) begin
              clr_col <= '0;
              if (clr_row != ROW_MAX) clr_row <= clr_row + 1'b1;
            end else begin
              clr_col <= clr_col + 1'b1;
            end
          end
        end
`endif
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_writer.sv
// tb/tb_vram_writer.sv - self-checking bench for vram_writer: vector table, corner sequences, random vs model.
module tb_vram_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, wr_en, busy;
  logic [5:0] wr_row, cursor_row;
  logic [6:0] wr_col, cursor_col;
  logic [7:0] wr_data;

  int vec = 0;
  int bad = 0;

  typedef struct { int r; int c; logic [7:0] d; } wr_t;
  wr_t exp_q[$];
  int  m_r = 0, m_c = 0;

  typedef struct {
    logic [7:0] d; logic we; int wr; int wc; logic [7:0] wd; int cr; int cc;
  } vec_t;
  vec_t tbl[18];

  always #5 clk = ~clk;

  vram_writer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: terminal semantics with whole-row/whole-screen clears as plain loops.
  task automatic push(input int r, input int c, input logic [7:0] d);
    wr_t w;
    w.r = r; w.c = c; w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic line_adv();
    m_r++;
    if (m_r == 60) begin
      m_r = 0;
      for (int c = 0; c < 80; c++) push(0, c, 8'h20);
    end
  endtask

  task automatic model(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push(m_r, m_c, b);
      m_c++;
      if (m_c == 80) begin m_c = 0; line_adv(); end
    end else if (b == 8'h0D) begin
      m_c = 0;
    end else if (b == 8'h0A) begin
      m_c = 0; line_adv();
    end else if (b == 8'h08) begin
      if (m_c > 0) m_c--;
      else if (m_r > 0) begin m_r--; m_c = 79; end
      push(m_r, m_c, 8'h20);
    end
`ifdef VRAM_WRITER_CLS_EN
    else if (b == 8'h0C) begin
      for (int r = 0; r < 60; r++)
        for (int c = 0; c < 80; c++) push(r, c, 8'h20);
      m_r = 0; m_c = 0;
    end
`endif
  endtask

  // Every RAM write must match the next one the model predicted.
  always @(negedge clk) begin
    if (rst === 1'b0 && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_row", int'(wr_row), -1);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("sb_wr_row", int'(wr_row), w.r);
        chk("sb_wr_col", int'(wr_col), w.c);
        chk("sb_wr_data", int'(wr_data), int'(w.d));
      end
    end
    if (rst === 1'b0) chk("busy_vs_ready", int'(busy), int'(!in_ready));
  end

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    m_r = 0; m_c = 0;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
    if (n >= 6000) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b1; in_data = b;
    @(posedge clk);
    #1 in_valid = 1'b0; in_data = 8'($urandom);
    model(b);
    chk("cursor_row", int'(cursor_row), m_r);
    chk("cursor_col", int'(cursor_col), m_c);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic goto_rc(input int r, input int c);
    do_reset();
    for (int i = 0; i < r; i++) send(8'h0A);
    for (int i = 0; i < c; i++) send(8'h78);
  endtask

  initial begin
    int n, wcnt, lr, lc;
    logic [7:0] b;

    tbl[0]  = '{8'h41, 1'b1, 0, 0,  8'h41, 0, 1};
    tbl[1]  = '{8'h42, 1'b1, 0, 1,  8'h42, 0, 2};
    tbl[2]  = '{8'h0D, 1'b0, 0, 0,  8'h00, 0, 0};
    tbl[3]  = '{8'h0A, 1'b0, 0, 0,  8'h00, 1, 0};
    tbl[4]  = '{8'h08, 1'b1, 0, 79, 8'h20, 0, 79};
    tbl[5]  = '{8'h08, 1'b1, 0, 78, 8'h20, 0, 78};
    tbl[6]  = '{8'h00, 1'b0, 0, 0,  8'h00, 0, 78};
    tbl[7]  = '{8'h7E, 1'b1, 0, 78, 8'h7E, 0, 79};
    tbl[8]  = '{8'h71, 1'b1, 0, 79, 8'h71, 1, 0};
    tbl[9]  = '{8'h7F, 1'b0, 0, 0,  8'h00, 1, 0};
    tbl[10] = '{8'h1B, 1'b0, 0, 0,  8'h00, 1, 0};
    tbl[11] = '{8'h20, 1'b1, 1, 0,  8'h20, 1, 1};
    tbl[12] = '{8'h08, 1'b1, 1, 0,  8'h20, 1, 0};
    tbl[13] = '{8'h0D, 1'b0, 0, 0,  8'h00, 1, 0};
    tbl[14] = '{8'h08, 1'b1, 0, 79, 8'h20, 0, 79};
    tbl[15] = '{8'h0D, 1'b0, 0, 0,  8'h00, 0, 0};
    tbl[16] = '{8'h08, 1'b1, 0, 0,  8'h20, 0, 0};
    tbl[17] = '{8'hFF, 1'b0, 0, 0,  8'h00, 0, 0};

    do_reset();
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_row", int'(wr_row), 0);
    chk("rst_wr_col", int'(wr_col), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cursor_row", int'(cursor_row), 0);
    chk("rst_cursor_col", int'(cursor_col), 0);

    for (int i = 0; i < 18; i++) begin
      send(tbl[i].d);
      chk("tbl_wr_en", int'(wr_en), int'(tbl[i].we));
      if (tbl[i].we) begin
        chk("tbl_wr_row", int'(wr_row), tbl[i].wr);
        chk("tbl_wr_col", int'(wr_col), tbl[i].wc);
        chk("tbl_wr_data", int'(wr_data), int'(tbl[i].wd));
      end
      chk("tbl_cursor_row", int'(cursor_row), tbl[i].cr);
      chk("tbl_cursor_col", int'(cursor_col), tbl[i].cc);
    end

    // End-of-line wrap without screen wrap.
    goto_rc(5, 79);
    send(8'h5A);
    chk("eol_wr_en", int'(wr_en), 1);
    chk("eol_wr_row", int'(wr_row), 5);
    chk("eol_wr_col", int'(wr_col), 79);
    chk("eol_wr_data", int'(wr_data), 8'h5A);
    chk("eol_cursor_row", int'(cursor_row), 6);
    chk("eol_cursor_col", int'(cursor_col), 0);
    chk("eol_in_ready", int'(in_ready), 1);

    // LF on the last row clears row 0 with in_ready low for exactly 80 cycles.
    goto_rc(59, 10);
    send(8'h0A);
    n = 0; wcnt = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      if (wr_en === 1'b1) wcnt++;
      @(posedge clk); #1;
      n++;
    end
    chk("clr_ready_low_cycles", n, 80);
    chk("clr_write_cycles", wcnt, 80);
    chk("clr_after_wr_en", int'(wr_en), 0);
    chk("clr_cursor_row", int'(cursor_row), 0);
    chk("clr_cursor_col", int'(cursor_col), 0);

    // Printable wrap on the last cell: own write first, then the row clear.
    goto_rc(59, 79);
    send(8'h51);
    chk("wrapchar_wr_row", int'(wr_row), 59);
    chk("wrapchar_wr_col", int'(wr_col), 79);
    chk("wrapchar_in_ready", int'(in_ready), 0);
    send(8'h52);

    // BS from the start of a row, and at the origin.
    goto_rc(3, 0);
    send(8'h08);
    chk("bs_wr_row", int'(wr_row), 2);
    chk("bs_wr_col", int'(wr_col), 79);
    chk("bs_wr_data", int'(wr_data), 8'h20);

    // Reset in the middle of a row clear.
    goto_rc(59, 0);
    send(8'h0A);
    repeat (40) begin @(posedge clk); #1; end
    chk("midclr_wr_col", int'(wr_col), 40);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); m_r = 0; m_c = 0;
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_cursor_row", int'(cursor_row), 0);
    chk("midrst_cursor_col", int'(cursor_col), 0);
    chk("midrst_in_ready", int'(in_ready), 1);

    // Form feed.
    goto_rc(2, 5);
    send(8'h0C);
`ifdef VRAM_WRITER_CLS_EN
    n = 0; wcnt = 0; lr = -1; lc = -1;
    while (in_ready !== 1'b1 && n < 6000) begin
      if (wr_en === 1'b1) begin wcnt++; lr = int'(wr_row); lc = int'(wr_col); end
      @(posedge clk); #1;
      n++;
    end
    chk("cls_writes", wcnt, 4800);
    chk("cls_last_row", lr, 59);
    chk("cls_last_col", lc, 79);
    chk("cls_cursor_row", int'(cursor_row), 0);
    chk("cls_cursor_col", int'(cursor_col), 0);
`else
    chk("ff_wr_en", int'(wr_en), 0);
    chk("ff_cursor_row", int'(cursor_row), 2);
    chk("ff_cursor_col", int'(cursor_col), 5);
`endif

    // Random traffic with idle gaps carrying garbage data.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      n = $urandom_range(0, 99);
      if (n < 10) idle_cycle();
      else begin
        if (n < 60)      b = 8'($urandom_range(32, 126));
        else if (n < 72) b = 8'h0A;
        else if (n < 77) b = 8'h0D;
        else if (n < 87) b = 8'h08;
        else begin
          b = 8'($urandom_range(0, 255));
          while ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h0A ||
                 b == 8'h0D || b == 8'h0C)
            b = 8'($urandom_range(0, 255));
        end
        send(b);
      end
    end

    n = 0;
    while (in_ready !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("pending_writes", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
